// File: rtl/fp16_mult_operand_prep.sv
// Operand-preparation stage ahead of the FP16 multiplier: captures a pair, classifies it,
// and iteratively pre-normalizes subnormal significands before presenting the result.
module fp16_mult_operand_prep #(
    parameter int NORM_STEP = 1
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] float1,
    input  logic [15:0] float2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_float1,
    output logic [15:0] out_float2,
    output logic        out_sign,
    output logic [2:0]  out_class1,
    output logic [2:0]  out_class2,
    output logic [10:0] out_sig1,
    output logic [10:0] out_sig2,
    output logic [6:0]  out_exp1,
    output logic [6:0]  out_exp2
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NORM = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    localparam logic [2:0] CLS_ZERO = 3'd0;
    localparam logic [2:0] CLS_SUB  = 3'd1;
    localparam logic [2:0] CLS_NORM = 3'd2;
    localparam logic [2:0] CLS_INF  = 3'd3;
    localparam logic [2:0] CLS_QNAN = 3'd4;
    localparam logic [2:0] CLS_SNAN = 3'd5;

    localparam logic [3:0] STEP = 4'(NORM_STEP);

    function automatic logic [2:0] classify(input logic [15:0] f);
        logic [2:0] c;
        if (f[14:10] == 5'd0)
            c = (f[9:0] == 10'd0) ? CLS_ZERO : CLS_SUB;
        else if (f[14:10] != 5'd31)
            c = CLS_NORM;
        else if (f[9:0] == 10'd0)
            c = CLS_INF;
        else if (f[9])
            c = CLS_QNAN;
        else
            c = CLS_SNAN;
        return c;
    endfunction

    function automatic logic [10:0] init_sig(input logic [15:0] f, input logic [2:0] c);
        return (c == CLS_NORM) ? {1'b1, f[9:0]} : {1'b0, f[9:0]};
    endfunction

    function automatic logic [6:0] init_exp(input logic [15:0] f, input logic [2:0] c);
        logic [6:0] e;
        case (c)
            CLS_NORM: e = {2'b00, f[14:10]} - 7'd15;
            CLS_SUB:  e = 7'h72;
            default:  e = 7'd0;
        endcase
        return e;
    endfunction

    function automatic logic [3:0] lzc11(input logic [10:0] s);
        logic [3:0] n;
        logic       found;
        n     = 4'd11;
        found = 1'b0;
        for (int i = 10; i >= 0; i--) begin
            if (!found && s[i]) begin
                n     = 4'(10 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

    // Shift is clamped to the leading-zero count so the leading one lands exactly on bit 10.
    function automatic logic [3:0] shift_amt(input logic [10:0] s, input logic [2:0] c);
        logic [3:0] lz;
        logic [3:0] amt;
        lz  = lzc11(s);
        amt = 4'd0;
        if (c == CLS_SUB && !s[10])
            amt = (lz > STEP) ? STEP : lz;
        return amt;
    endfunction

    state_t      state_q, state_d;
    logic        valid_q, valid_d;
    logic [15:0] f1_q, f1_d, f2_q, f2_d;
    logic        sign_q, sign_d;
    logic [2:0]  cls1_q, cls1_d, cls2_q, cls2_d;
    logic [10:0] sig1_q, sig1_d, sig2_q, sig2_d;
    logic [6:0]  exp1_q, exp1_d, exp2_q, exp2_d;

    logic        accept;
    logic [2:0]  new_cls1, new_cls2;
    logic [3:0]  amt1, amt2;
    logic [10:0] nsig1, nsig2;
    logic        norm_done;

    assign in_ready = !flush && ((state_q == ST_IDLE) || (state_q == ST_OUT && out_ready));
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        f1_d    = f1_q;
        f2_d    = f2_q;
        sign_d  = sign_q;
        cls1_d  = cls1_q;
        cls2_d  = cls2_q;
        sig1_d  = sig1_q;
        sig2_d  = sig2_q;
        exp1_d  = exp1_q;
        exp2_d  = exp2_q;

        new_cls1  = classify(float1);
        new_cls2  = classify(float2);
        amt1      = shift_amt(sig1_q, cls1_q);
        amt2      = shift_amt(sig2_q, cls2_q);
        nsig1     = sig1_q << amt1;
        nsig2     = sig2_q << amt2;
        norm_done = (nsig1[10] || cls1_q != CLS_SUB) && (nsig2[10] || cls2_q != CLS_SUB);

        case (state_q)
            ST_NORM: begin
                sig1_d = nsig1;
                sig2_d = nsig2;
                exp1_d = exp1_q - {3'b000, amt1};
                exp2_d = exp2_q - {3'b000, amt2};
                if (norm_done) begin
                    state_d = ST_OUT;
                    valid_d = 1'b1;
                end
            end
            ST_OUT: begin
                if (out_ready && !accept) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end
            end
            ST_IDLE: ;
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase

        // A capture overrides the IDLE/OUT defaults above; in NORM accept is never high.
        if (accept) begin
            f1_d   = float1;
            f2_d   = float2;
            sign_d = float1[15] ^ float2[15];
            cls1_d = new_cls1;
            cls2_d = new_cls2;
            sig1_d = init_sig(float1, new_cls1);
            sig2_d = init_sig(float2, new_cls2);
            exp1_d = init_exp(float1, new_cls1);
            exp2_d = init_exp(float2, new_cls2);
            if (new_cls1 == CLS_SUB || new_cls2 == CLS_SUB) begin
                state_d = ST_NORM;
                valid_d = 1'b0;
            end else begin
                state_d = ST_OUT;
                valid_d = 1'b1;
            end
        end

        if (flush) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            f1_q    <= 16'd0;
            f2_q    <= 16'd0;
            sign_q  <= 1'b0;
            cls1_q  <= CLS_ZERO;
            cls2_q  <= CLS_ZERO;
            sig1_q  <= 11'd0;
            sig2_q  <= 11'd0;
            exp1_q  <= 7'd0;
            exp2_q  <= 7'd0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            f1_q    <= f1_d;
            f2_q    <= f2_d;
            sign_q  <= sign_d;
            cls1_q  <= cls1_d;
            cls2_q  <= cls2_d;
            sig1_q  <= sig1_d;
            sig2_q  <= sig2_d;
            exp1_q  <= exp1_d;
            exp2_q  <= exp2_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_float1 = f1_q;
    assign out_float2 = f2_q;
    assign out_sign   = sign_q;
    assign out_class1 = cls1_q;
    assign out_class2 = cls2_q;
    assign out_sig1   = sig1_q;
    assign out_sig2   = sig2_q;
    assign out_exp1   = exp1_q;
    assign out_exp2   = exp2_q;

endmodule
